dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter_rr_pick2.sv | 21 ++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, port IDs
// and the debug-streak limit used by the starvation guard.
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int STREAK_MAX = 4;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } port_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core/debug requesters, the arbiter and the memory.
// The slave modport is the arbiter's view; master is the environment's.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata, core_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata, core_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker; bit 0 is the core, bit 1 the debug port.
// force_core overrides the pointer on a contested cycle.
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  port_e      last_win,
    input  logic       force_core,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || force_core || (last_win == PORT_DBG))) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter in front of a single-port data memory. Grants are
// combinational; read data returns to the winning port one cycle later.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    port_e             last_win;
    port_e             win_port;
    logic [1:0]        streak;
    logic              lock;
    logic              rd_valid;
    port_e             rd_port;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              core_rvalid;
    logic              dbg_rvalid;

    // Masking with reset keeps grants and the memory strobe quiet during reset.
    assign req = {bus.dbg_req, bus.core_req} & {2{reset}};

    rr_pick2 u_pick (
        .req        (req),
        .last_win   (last_win),
        .force_core (lock),
        .gnt        (gnt)
    );

    always_comb begin
        win_port  = PORT_CORE;
        win_we    = bus.core_we;
        win_addr  = bus.core_addr;
        win_wdata = bus.core_wdata;
        if (gnt[1]) begin
            win_port  = PORT_DBG;
            win_we    = bus.dbg_we;
            win_addr  = bus.dbg_addr;
            win_wdata = bus.dbg_wdata;
        end
    end

    assign bus.core_gnt   = gnt[0];
    assign bus.dbg_gnt    = gnt[1];
    assign bus.core_stall = req[0] & ~gnt[0];

    assign bus.mem_en    = |gnt;
    assign bus.mem_we    = (|gnt) & win_we;
    assign bus.mem_addr  = (|gnt) ? win_addr  : addr_q;
    assign bus.mem_wdata = (|gnt) ? win_wdata : wdata_q;

    assign core_rvalid     = rd_valid && (rd_port == PORT_CORE);
    assign dbg_rvalid      = rd_valid && (rd_port == PORT_DBG);
    assign bus.core_rvalid = core_rvalid;
    assign bus.dbg_rvalid  = dbg_rvalid;
    assign bus.core_rdata  = core_rvalid ? bus.mem_rdata : core_rdata_q;
    assign bus.dbg_rdata   = dbg_rvalid  ? bus.mem_rdata : dbg_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_win     <= PORT_DBG;
            streak       <= 2'd0;
            lock         <= 1'b0;
            rd_valid     <= 1'b0;
            rd_port      <= PORT_CORE;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            rd_valid <= (|gnt) & ~win_we;
            if (|gnt) begin
                rd_port  <= win_port;
                last_win <= win_port;
                addr_q   <= win_addr;
                wdata_q  <= win_wdata;
            end
            // streak saturates at 3; the grant that finds it at 3 is the 4th in a row
            if (gnt[0]) begin
                streak <= 2'd0;
                lock   <= 1'b0;
            end else if (gnt[1]) begin
                if (streak == 2'(STREAK_MAX - 1)) begin
                    lock <= 1'b1;
                end else begin
                    streak <= streak + 2'd1;
                end
            end
            if (core_rvalid) core_rdata_q <= bus.mem_rdata;
            if (dbg_rvalid)  dbg_rdata_q  <= bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic checked against a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Synchronous single-port RAM with one-cycle read latency.
    logic [DW-1:0] ram [1024];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_last;
    int          m_run;
    bit          p_valid;
    int          p_port;
    logic [31:0] p_data;
    logic [31:0] h_core, h_dbg;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_mem [1024];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last  = 1;
        m_run   = 0;
        p_valid = 1'b0;
        p_port  = 0;
        p_data  = '0;
        h_core  = '0;
        h_dbg   = '0;
        m_addr  = '0;
        m_wdata = '0;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [9:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [9:0] da, input logic [31:0] dd);
        bus.core_req   = cr;
        bus.core_we    = cw;
        bus.core_addr  = ca;
        bus.core_wdata = cd;
        bus.dbg_req    = dr;
        bus.dbg_we     = dw;
        bus.dbg_addr   = da;
        bus.dbg_wdata  = dd;
    endtask

    // Called at the negedge: compares every output with the model, then advances it.
    task automatic model_cycle(output logic [1:0] g);
        logic        cr, dr, we, crv, drv;
        logic [9:0]  a;
        logic [31:0] d, crd, drd;
        cr = bus.core_req;
        dr = bus.dbg_req;
        if (cr && dr) g = (m_run >= STREAK_MAX || m_last == 1) ? 2'b01 : 2'b10;
        else          g = {dr, cr};
        we = g[1] ? bus.dbg_we    : bus.core_we;
        a  = g[1] ? bus.dbg_addr  : bus.core_addr;
        d  = g[1] ? bus.dbg_wdata : bus.core_wdata;
        crv = p_valid && p_port == 0;
        drv = p_valid && p_port == 1;
        crd = crv ? p_data : h_core;
        drd = drv ? p_data : h_dbg;

        check("grant_stall", {61'd0, bus.dbg_gnt, bus.core_gnt, bus.core_stall},
              {61'd0, g[1], g[0], cr & ~g[0]});
        if (g != 2'b00)
            check("mem_bus", {20'd0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                  {20'd0, 1'b1, we, a, d});
        else
            check("mem_bus_idle", {20'd0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                  {20'd0, 1'b0, 1'b0, m_addr, m_wdata});
        check("rvalid", {62'd0, bus.dbg_rvalid, bus.core_rvalid}, {62'd0, drv, crv});
        check("rdata", {bus.dbg_rdata, bus.core_rdata}, {drd, crd});

        h_core = crd;
        h_dbg  = drd;
        p_valid = 1'b0;
        if (g != 2'b00) begin
            m_last  = g[1] ? 1 : 0;
            m_run   = g[1] ? m_run + 1 : 0;
            m_addr  = a;
            m_wdata = d;
            if (we) begin
                m_mem[a] = d;
            end else begin
                p_valid = 1'b1;
                p_port  = g[1] ? 1 : 0;
                p_data  = m_mem[a];
            end
        end
    endtask

    task automatic step(output logic [1:0] g);
        @(negedge clk);
        model_cycle(g);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {57'd0, bus.core_gnt, bus.dbg_gnt, bus.core_rvalid, bus.dbg_rvalid,
                               bus.core_stall, bus.mem_en, bus.mem_we}, 64'd0);
        check({name, "_bus"}, {22'd0, bus.mem_addr, bus.mem_wdata}, 64'd0);
        check({name, "_rdata"}, {bus.core_rdata, bus.dbg_rdata}, 64'd0);
    endtask

    typedef struct {
        logic        cr, cw;
        logic [9:0]  ca;
        logic [31:0] cd;
        logic        dr, dw;
        logic [9:0]  da;
        logic [31:0] dd;
        logic [1:0]  gnt;   // {dbg, core}
        logic [1:0]  rv;    // {dbg, core}
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [19];

    initial begin
        logic [1:0]  g;
        logic        cr, cw, dr, dw;
        logic [9:0]  ca, da;
        logic [31:0] cd, dd;

        tbl[0]  = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0,      2'b01, 2'b00, 0};
        tbl[1]  = '{1, 0, 5, 0,            0, 0, 0, 0,      2'b01, 2'b00, 0};
        tbl[2]  = '{0, 0, 0, 0,            0, 0, 0, 0,      2'b00, 2'b01, 32'hDEADBEEF};
        tbl[3]  = '{0, 0, 0, 0,            1, 1, 0, 'h13,   2'b10, 2'b00, 0};
        tbl[4]  = '{0, 0, 0, 0,            1, 1, 1, 'h93,   2'b10, 2'b00, 0};
        tbl[5]  = '{0, 0, 0, 0,            1, 1, 2, 'h113,  2'b10, 2'b00, 0};
        tbl[6]  = '{0, 0, 0, 0,            1, 1, 3, 'h193,  2'b10, 2'b00, 0};
        tbl[7]  = '{1, 0, 0, 0,            0, 0, 0, 0,      2'b01, 2'b00, 0};
        tbl[8]  = '{1, 0, 1, 0,            0, 0, 0, 0,      2'b01, 2'b01, 'h13};
        tbl[9]  = '{1, 0, 2, 0,            0, 0, 0, 0,      2'b01, 2'b01, 'h93};
        tbl[10] = '{1, 0, 3, 0,            0, 0, 0, 0,      2'b01, 2'b01, 'h113};
        tbl[11] = '{0, 0, 0, 0,            0, 0, 0, 0,      2'b00, 2'b01, 'h193};
        tbl[12] = '{1, 0, 1, 0,            0, 0, 0, 0,      2'b01, 2'b00, 0};
        tbl[13] = '{0, 0, 0, 0,            1, 0, 2, 0,      2'b10, 2'b01, 'h93};
        tbl[14] = '{1, 0, 3, 0,            0, 0, 0, 0,      2'b01, 2'b10, 'h113};
        tbl[15] = '{0, 0, 0, 0,            0, 0, 0, 0,      2'b00, 2'b01, 'h193};
        tbl[16] = '{1, 0, 0, 0,            1, 0, 1, 0,      2'b10, 2'b00, 0};
        tbl[17] = '{1, 0, 0, 0,            0, 0, 0, 0,      2'b01, 2'b10, 'h93};
        tbl[18] = '{0, 0, 0, 0,            0, 0, 0, 0,      2'b00, 2'b01, 'h13};

        // Reset with both ports requesting: nothing may leak out.
        model_reset();
        drive(1, 0, 7, 32'h55, 1, 1, 9, 32'hAA);
        @(negedge clk);
        check_reset_outputs("reset_init");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
                  tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
            @(negedge clk);
            model_cycle(g);
            check($sformatf("tbl%0d_gnt", i), {62'd0, bus.dbg_gnt, bus.core_gnt}, {62'd0, tbl[i].gnt});
            check($sformatf("tbl%0d_rvalid", i), {62'd0, bus.dbg_rvalid, bus.core_rvalid}, {62'd0, tbl[i].rv});
            if (tbl[i].rv[0]) check($sformatf("tbl%0d_core_rdata", i), {32'd0, bus.core_rdata}, {32'd0, tbl[i].rd});
            if (tbl[i].rv[1]) check($sformatf("tbl%0d_dbg_rdata", i), {32'd0, bus.dbg_rdata}, {32'd0, tbl[i].rd});
            @(posedge clk);
            #1;
        end

        // Both ports request continuously from reset: core, dbg, core, dbg ...
        rst_n = 1'b0;
        model_reset();
        drive(1, 0, 0, 0, 1, 0, 1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            model_cycle(g);
            check("alt_gnt", {62'd0, bus.dbg_gnt, bus.core_gnt}, (i % 2 == 0) ? 64'd1 : 64'd2);
            check("alt_stall", {63'd0, bus.core_stall}, (i % 2 == 0) ? 64'd0 : 64'd1);
            @(posedge clk);
            #1;
        end

        // Four debug grants in a row, then the core must win the next contested cycle.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 1, 10'(20 + i), 32'h1000 + 32'(i));
            @(negedge clk);
            model_cycle(g);
            check("streak_dbg_gnt", {63'd0, bus.dbg_gnt}, 64'd1);
            @(posedge clk);
            #1;
        end
        drive(1, 0, 20, 0, 1, 1, 24, 32'h2000);
        @(negedge clk);
        model_cycle(g);
        check("streak_core_wins", {62'd0, bus.dbg_gnt, bus.core_gnt}, 64'd1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(g);
        step(g);

        // Reset while a core load is in flight: the load is dropped.
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        model_cycle(g);
        check("inflight_gnt", {63'd0, bus.core_gnt}, 64'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid");
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            model_cycle(g);
            check("no_rvalid_after_reset", {62'd0, bus.dbg_rvalid, bus.core_rvalid}, 64'd0);
            @(posedge clk);
            #1;
        end
        drive(1, 0, 0, 0, 1, 0, 1, 0);
        @(negedge clk);
        model_cycle(g);
        check("first_tie_core", {62'd0, bus.dbg_gnt, bus.core_gnt}, 64'd1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(g);

        // Fill the low 16 words so every random read hits known data.
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 1, 1, 10'(i), $urandom);
            step(g);
        end

        // Randomized traffic; each requester holds its request until granted.
        cr = 0; cw = 0; ca = 0; cd = 0;
        dr = 0; dw = 0; da = 0; dd = 0;
        for (int i = 0; i < 400; i++) begin
            if (!cr) begin
                cr = ($urandom_range(0, 99) < 60);
                cw = 1'($urandom_range(0, 1));
                ca = 10'($urandom_range(0, 15));
                cd = $urandom;
            end
            if (!dr) begin
                dr = ($urandom_range(0, 99) < 50);
                dw = 1'($urandom_range(0, 1));
                da = 10'($urandom_range(0, 15));
                dd = $urandom;
            end
            drive(cr, cw, ca, cd, dr, dw, da, dd);
            step(g);
            if (g[0]) cr = 0;
            if (g[1]) dr = 0;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(g);
        step(g);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
